spdif_input_monitor: RTL and testbench

Parametrised multi-channel S/PDIF input front-end for the audio DAC board top level. It synchronises and optionally glitch-filters up to CHANNELS raw S/PDIF pins and routes one selected channel to a true/complement output pair, either sampled per window or passed through. It also measures edge count per window on the selected channel for rate detection, and drives per-channel stretched activity flags for LEDs.

---
 rtl/spdif_monitor_pkg.sv | 20 ++
 rtl/spdif_channel_filter.sv | 85 ++++++++
 rtl/spdif_input_monitor.sv | 145 ++++++++++++++
 tb/tb_spdif_input_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_monitor_pkg.sv
// spdif_monitor_pkg: shared constants and helpers for the S/PDIF input monitor.
// Holds the channel-select width function, the legal parameter ranges and
// the Mode encoding used by spdif_input_monitor and spdif_channel_filter.
package spdif_monitor_pkg;

  // Legal configuration ranges.
  localparam int MAX_CHANNELS   = 8;
  localparam int MIN_FILTER_LEN = 2;
  localparam int MAX_FILTER_LEN = 15;

  // Mode input encoding.
  localparam logic MODE_WINDOW = 1'b0;
  localparam logic MODE_PASS   = 1'b1;

  // Width of the channel-select bus; a single channel still needs one bit.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/spdif_channel_filter.sv
// spdif_channel_filter: per-pin front end of the S/PDIF monitor.
// Two-flop synchroniser, optional glitch filter (built only when
// SPDIF_INPUT_MONITOR_FILTER_EN is defined) and an activity stretcher that
// keeps Activity high for 2^STRETCH_WIDTH-1 cycles after the last F edge.
module spdif_channel_filter
  import spdif_monitor_pkg::*;
#(
  parameter int FILTER_LEN    = 3,
  parameter int STRETCH_WIDTH = 22
) (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic F,
  output logic Activity
);

  logic sync_meta;
  logic sync_out;

  // Two-flop synchroniser for the asynchronous pin.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source, exactly like the hardware it describes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= In;
      sync_out  <= sync_meta;
    end
  end

`ifdef SPDIF_INPUT_MONITOR_FILTER_EN
  localparam int RUN_W = $clog2(MAX_FILTER_LEN);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

  logic             f_q;
  logic [RUN_W-1:0] run_cnt;

  // Accept a level change only after FILTER_LEN consecutive differing samples;
  // any sample equal to the current level restarts the run.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      f_q     <= 1'b0;
      run_cnt <= '0;
    end else if (sync_out == f_q) begin
      run_cnt <= '0;
    end else if (run_cnt == RUN_LAST) begin
      f_q     <= sync_out;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign F = f_q;
`else
  // Without the filter FILTER_LEN has no effect; kept for a uniform interface.
  localparam int filter_len_unused = FILTER_LEN;

  assign F = sync_out;
`endif

  logic                     f_d;
  logic [STRETCH_WIDTH-1:0] stretch;

  // Activity stretcher: reload on any F edge, otherwise count down to zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      f_d     <= 1'b0;
      stretch <= '0;
    end else begin
      f_d <= F;
      if (F != f_d) begin
        stretch <= '1;
      end else if (stretch != '0) begin
        stretch <= stretch - 1'b1;
      end
    end
  end

  assign Activity = (stretch != '0);

endmodule

// File: rtl/spdif_input_monitor.sv
// spdif_input_monitor: multi-channel S/PDIF input front-end.
// Routes one filtered channel (select latched at window boundaries) to a
// true/complement output pair, windowed (Mode 0) or passed through (Mode 1),
// counts edges per 2^DIV_WIDTH-cycle window and exposes per-channel activity.
// Optional glitch filter: define SPDIF_INPUT_MONITOR_FILTER_EN.
module spdif_input_monitor
  import spdif_monitor_pkg::*;
#(
  parameter int  CHANNELS      = 1,
  parameter int  DIV_WIDTH     = 27,
  parameter int  CNT_WIDTH     = 16,
  parameter int  FILTER_LEN    = 3,
  parameter int  STRETCH_WIDTH = 22,
  localparam int SEL_W         = sel_width(CHANNELS)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [CHANNELS-1:0]  In,
  input  logic [SEL_W-1:0]     Sel,
  input  logic                 Mode,
  output logic                 Out,
  output logic                 nOut,
  output logic                 Strobe,
  output logic [CNT_WIDTH-1:0] Edge_Count,
  output logic                 Count_Valid,
  output logic [CHANNELS-1:0]  Activity
);

  // Keep the filter length inside the range its run counter can represent.
  localparam int FILTER_LEN_C = (FILTER_LEN < MIN_FILTER_LEN) ? MIN_FILTER_LEN :
                                (FILTER_LEN > MAX_FILTER_LEN) ? MAX_FILTER_LEN :
                                FILTER_LEN;

  logic [CHANNELS-1:0] f;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    spdif_channel_filter #(
      .FILTER_LEN    (FILTER_LEN_C),
      .STRETCH_WIDTH (STRETCH_WIDTH)
    ) u_chan (
      .Clk      (Clk),
      .Reset    (Reset),
      .In       (In[i]),
      .F        (f[i]),
      .Activity (Activity[i])
    );
  end

  logic [DIV_WIDTH-1:0] win_cnt;

  // Free-running window counter; Strobe marks its last cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  assign Strobe = &win_cnt;

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_next;

  // Next selected channel: only moves on Strobe, out-of-range falls back to 0.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_next = sel_q;
    if (Strobe) begin
      if (int'(Sel) < CHANNELS) begin
        sel_next = Sel;
      end else begin
        sel_next = '0;
      end
    end
  end

  // Select latch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_next;
    end
  end

  logic f_sel;
  logic f_new;

  assign f_sel = f[sel_q];
  assign f_new = f[sel_next];

  logic out_load;

  // Output registers load every cycle in passthrough, only on Strobe when windowed.
  always_comb begin
    out_load = Strobe;
    case (Mode)
      MODE_WINDOW: out_load = Strobe;
      MODE_PASS:   out_load = 1'b1;
      default:     out_load = Strobe;
    endcase
  end

  // True/complement output pair.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out  <= 1'b0;
      nOut <= 1'b1;
    end else if (out_load) begin
      Out  <= f_sel;
      nOut <= ~f_sel;
    end
  end

  logic                 hist;
  logic                 edge_now;
  logic [CNT_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] acc_inc;

  assign edge_now = f_sel ^ hist;
  assign acc_inc  = (edge_now && (acc != '1)) ? acc + 1'b1 : acc;

  // Edge accumulator. The history register tracks the channel that will be
  // selected next cycle, so a select switch alone never looks like an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hist        <= 1'b0;
      acc         <= '0;
      Edge_Count  <= '0;
      Count_Valid <= 1'b0;
    end else begin
      hist        <= f_new;
      Count_Valid <= Strobe;
      if (Strobe) begin
        Edge_Count <= acc_inc;
        acc        <= '0;
      end else begin
        acc <= acc_inc;
      end
    end
  end

endmodule

// File: tb/tb_spdif_input_monitor.sv
// tb_spdif_input_monitor: directed self-checking bench for spdif_input_monitor.
// Main DUT: CHANNELS=2, DIV_WIDTH=4, CNT_WIDTH=16, STRETCH_WIDTH=4.
// Second DUT with CNT_WIDTH=3 shares all inputs for the saturation case.
module tb_spdif_input_monitor;

  localparam int WIN = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [0:0]  Sel = 1'b0;
  logic        Mode = 1'b1;
  logic [1:0]  In;
  logic        in0 = 1'b0;
  logic        in1 = 1'b0;
  logic        tog_q = 1'b0;
  int          tog_period = 0;
  int          tog_cnt = 0;

  logic        Out, nOut, Strobe, Count_Valid;
  logic [15:0] Edge_Count;
  logic [1:0]  Activity;

  logic        sat_out, sat_nout, sat_strobe, sat_cv;
  logic [2:0]  sat_count;
  logic [1:0]  sat_act;

  int checks = 0;
  int errors = 0;

  // Channel 0 is either driven directly or by the periodic toggler.
  assign In = {in1, (tog_period != 0) ? tog_q : in0};

  spdif_input_monitor #(
    .CHANNELS(2), .DIV_WIDTH(4), .CNT_WIDTH(16), .FILTER_LEN(3), .STRETCH_WIDTH(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .In(In), .Sel(Sel), .Mode(Mode),
    .Out(Out), .nOut(nOut), .Strobe(Strobe), .Edge_Count(Edge_Count),
    .Count_Valid(Count_Valid), .Activity(Activity)
  );

  spdif_input_monitor #(
    .CHANNELS(2), .DIV_WIDTH(4), .CNT_WIDTH(3), .FILTER_LEN(3), .STRETCH_WIDTH(4)
  ) u_sat (
    .Clk(Clk), .Reset(Reset), .In(In), .Sel(Sel), .Mode(Mode),
    .Out(sat_out), .nOut(sat_nout), .Strobe(sat_strobe), .Edge_Count(sat_count),
    .Count_Valid(sat_cv), .Activity(sat_act)
  );

  always #5 Clk = ~Clk;

  // Periodic toggler for channel 0, changing on the falling edge.
  always @(negedge Clk) begin
    if (tog_period != 0) begin
      tog_cnt = tog_cnt + 1;
      if (tog_cnt >= tog_period) begin
        tog_cnt = 0;
        tog_q   = ~tog_q;
      end
    end
  end

  // Reference model of the two-flop synchroniser (filter compiled out).
  logic [1:0] m_s1, m_f;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_s1 <= 2'b00;
      m_f  <= 2'b00;
    end else begin
      m_s1 <= In;
      m_f  <= m_s1;
    end
  end

  // Wait for the next Count_Valid; n = cycles waited, -1 on timeout.
  task automatic wait_cv(output int n);
    n = -1;
    for (int i = 1; i <= 3 * WIN; i++) begin
      @(negedge Clk);
      if (Count_Valid === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL cv_timeout no Count_Valid within %0d cycles", 3 * WIN);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Out, nOut, Strobe, Count_Valid} !== 4'b0100 || Edge_Count !== 16'd0 || Activity !== 2'b00) begin
      errors++;
      $display("FAIL reset_values got Out=%b nOut=%b Strobe=%b CV=%b EC=%0d Act=%b exp 0 1 0 0 0 00",
               Out, nOut, Strobe, Count_Valid, Edge_Count, Activity);
    end
    Reset = 1'b0;
    in0 = 1'b1; in1 = 1'b1; Mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (i == 6) begin
        checks++;
        if (Out !== 1'b1 || nOut !== 1'b0 || Activity !== 2'b11) begin
          errors++;
          $display("FAIL pass_follow got Out=%b nOut=%b Act=%b exp 1 0 11", Out, nOut, Activity);
        end
      end
      if (i == 15) begin
        checks++;
        if (Strobe !== 1'b1) begin
          errors++;
          $display("FAIL first_strobe got Strobe=%b exp 1 at cycle 15", Strobe);
        end
        in0 = 1'b0; in1 = 1'b0;
      end
      if (i == 17) begin
        in0 = 1'b1; in1 = 1'b1;
      end
    end
    checks++;
    if (Out !== 1'b1 || Activity !== 2'b11 || Edge_Count !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset got Out=%b Act=%b EC=%0d exp 1 11 1", Out, Activity, Edge_Count);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (Out !== 1'b0 || nOut !== 1'b1 || Activity !== 2'b00 || Edge_Count !== 16'd0
        || Strobe !== 1'b0 || Count_Valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got Out=%b nOut=%b Act=%b EC=%0d Strobe=%b CV=%b exp 0 1 00 0 0 0",
               Out, nOut, Activity, Edge_Count, Strobe, Count_Valid);
    end
    @(negedge Clk);
    Reset = 1'b0;
    n = -1;
    for (int i = 1; i <= 2 * WIN; i++) begin
      @(negedge Clk);
      if (Strobe === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL strobe_latency got %0d exp 15", n);
    end
  endtask

  task automatic test_rate();
    int n;
    in0 = 1'b0; in1 = 1'b0; Sel = 1'b0;
    tog_period = 2;
    wait_cv(n);
    for (int k = 0; k < 3; k++) begin
      wait_cv(n);
      checks++;
      if (Edge_Count !== 16'd8) begin
        errors++;
        $display("FAIL rate_count[%0d] got %0d exp 8", k, Edge_Count);
      end
      if (k > 0) begin
        checks++;
        if (n != WIN) begin
          errors++;
          $display("FAIL cv_period got %0d exp %0d", n, WIN);
        end
      end
    end
    @(negedge Clk);
    checks++;
    if (Count_Valid !== 1'b0) begin
      errors++;
      $display("FAIL cv_width got %b exp 0", Count_Valid);
    end
  endtask

  task automatic test_saturation();
    int n;
    tog_period = 1;
    wait_cv(n);
    for (int k = 0; k < 2; k++) begin
      wait_cv(n);
      checks++;
      if (Edge_Count !== 16'd16) begin
        errors++;
        $display("FAIL full_rate_count got %0d exp 16", Edge_Count);
      end
      checks++;
      if (sat_count !== 3'd7 || sat_cv !== 1'b1) begin
        errors++;
        $display("FAIL saturate got %0d cv=%b exp 7 cv=1", sat_count, sat_cv);
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    int run;
    tog_period = 0;
    in0 = 1'b0;
    repeat (3) wait_cv(n);
    checks++;
    if (Edge_Count !== 16'd0 || Activity !== 2'b00) begin
      errors++;
      $display("FAIL quiet got EC=%0d Act=%b exp 0 00", Edge_Count, Activity);
    end
    in0 = 1'b1;
    repeat (2) @(negedge Clk);
    in0 = 1'b0;
    repeat (3) @(negedge Clk);
    run = 0;
    for (int i = 0; i < 40; i++) begin
      if (Activity[0] !== 1'b1) break;
      run++;
      @(negedge Clk);
    end
`ifdef SPDIF_INPUT_MONITOR_FILTER_EN
    checks++;
    if (run != 0 || Edge_Count !== 16'd0) begin
      errors++;
      $display("FAIL glitch_filtered got run=%0d EC=%0d exp 0 0", run, Edge_Count);
    end
`else
    checks++;
    if (run != 15) begin
      errors++;
      $display("FAIL glitch_activity got %0d cycles exp 15", run);
    end
    checks++;
    if (Edge_Count !== 16'd2) begin
      errors++;
      $display("FAIL glitch_edges got %0d exp 2", Edge_Count);
    end
`endif
    checks++;
    if (Activity[1] !== 1'b0) begin
      errors++;
      $display("FAIL idle_activity got %b exp 0", Activity[1]);
    end
  endtask

  task automatic test_mode0_hold();
    logic prev_out;
    logic exp_out;
    bit   have_exp;
    int   strobes;
    Mode = 1'b0;
    tog_period = 3;
    @(negedge Clk);
    prev_out = Out;
    have_exp = 1'b0;
    strobes  = 0;
    for (int i = 0; i < 4 * WIN; i++) begin
      @(negedge Clk);
      checks++;
      if (nOut !== ~Out) begin
        errors++;
        $display("FAIL complement got Out=%b nOut=%b", Out, nOut);
      end
      checks++;
      if (Out !== prev_out && Count_Valid !== 1'b1) begin
        errors++;
        $display("FAIL mode0_hold got Out %b->%b off window boundary", prev_out, Out);
      end
      if (have_exp && Count_Valid === 1'b1) begin
        checks++;
        if (Out !== exp_out) begin
          errors++;
          $display("FAIL mode0_sample got %b exp %b", Out, exp_out);
        end
        have_exp = 1'b0;
      end
      if (Strobe === 1'b1) begin
        exp_out  = m_f[0];
        have_exp = 1'b1;
        strobes++;
      end
      prev_out = Out;
    end
    checks++;
    if (strobes != 4) begin
      errors++;
      $display("FAIL mode0_strobes got %0d exp 4", strobes);
    end
  endtask

  task automatic test_channel_switch();
    int n;
    Mode = 1'b0;
    Sel  = 1'b0;
    in1  = 1'b1;
    tog_period = 2;
    repeat (2) wait_cv(n);
    repeat (5) @(negedge Clk);
    Sel = 1'b1;
    wait_cv(n);
    checks++;
    if (Edge_Count !== 16'd8) begin
      errors++;
      $display("FAIL switch_old_window got %0d exp 8", Edge_Count);
    end
    wait_cv(n);
    checks++;
    if (Edge_Count !== 16'd0) begin
      errors++;
      $display("FAIL switch_new_window got %0d exp 0", Edge_Count);
    end
    checks++;
    if (Out !== 1'b1 || nOut !== 1'b0) begin
      errors++;
      $display("FAIL switch_out got Out=%b nOut=%b exp 1 0", Out, nOut);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rate();
    test_saturation();
    test_glitch();
    test_mode0_hold();
    test_channel_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
